half_precision_mult: RTL



---
 rtl/fp16_pkg.sv | 47 ++++
 rtl/half_precision_mult_round_pack.sv | 44 ++++
 rtl/half_precision_mult.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/fp16_pkg.sv
// fp16_pkg: binary16 types, constants and helpers
// shared by the sparse-matrix MAC multiply and add units
package fp16_pkg;

  localparam int          FP16_BIAS    = 15;
  localparam logic [4:0]  FP16_EXP_MAX = 5'h1F;
  localparam logic [15:0] FP16_QNAN    = 16'h7E00;

  typedef struct packed {
    logic       sign;
    logic [4:0] exp;
    logic [9:0] frac;
  } fp16_t;

  typedef enum logic [1:0] {
    ZERO,
    NORMAL,
    INF,
    NAN
  } fp16_class_t;

  typedef enum logic [2:0] {
    IDLE,
    UNPACK,
    MULT,
    NORM,
    DONE
  } mult_state_t;

  // subnormals classify as ZERO so they flush
  function automatic fp16_class_t fp16_classify(input fp16_t x);
    fp16_class_t c;
    c = NORMAL;
    unique case (1'b1)
      (x.exp == 5'd0):
        c = ZERO;
      (x.exp == FP16_EXP_MAX && x.frac == 10'd0):
        c = INF;
      (x.exp == FP16_EXP_MAX && x.frac != 10'd0):
        c = NAN;
      default:
        c = NORMAL;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/half_precision_mult_round_pack.sv
// fp16_round_pack: RNE rounding and binary16 packing
// with overflow-to-inf and flush-to-zero underflow
module fp16_round_pack
  import fp16_pkg::*;
(
  input  logic              sign,
  input  logic signed [6:0] exp_in,
  input  logic [10:0]       sig,
  input  logic              guard,
  input  logic              sticky,
  output fp16_t             result,
  output logic              v,
  output logic              z
);

  logic              rnd;
  logic [11:0]       sum;
  logic              carry;
  logic              hidden;
  logic signed [7:0] exp_fin;

  // round, renormalise on carry-out, then range-check exponent
  always_comb begin
    rnd     = guard & (sticky | sig[0]);
    sum     = {1'b0, sig} + {11'd0, rnd};
    carry   = sum[11];
    hidden  = sum[11] | sum[10];
    exp_fin = {exp_in[6], exp_in} + {7'd0, carry};
    result  = {sign, exp_fin[4:0], sum[9:0]};
    v       = 1'b0;
    z       = 1'b0;
    if (!hidden) begin
      result = {sign, 15'h0};
      z      = 1'b1;
    end else if (exp_fin >= 8'sd31) begin
      result = {sign, FP16_EXP_MAX, 10'h0};
      v      = 1'b1;
    end else if (exp_fin <= 8'sd0) begin
      result = {sign, 15'h0};
      z      = 1'b1;
    end
  end

endmodule

// File: rtl/half_precision_mult.sv
// half_precision_mult: multi-cycle binary16 multiplier
// IDLE/UNPACK/MULT/NORM/DONE with a one-cycle ready pulse
module half_precision_mult
  import fp16_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] A,
  input  logic [15:0] B,
  output logic [15:0] product,
  output logic        n,
  output logic        v,
  output logic        z,
  output logic        ready
);

  mult_state_t state, state_nxt;

  fp16_t a_q, b_q;

  logic        sign_u;
  fp16_class_t cls_a, cls_b;
  logic [10:0] sig_a, sig_b;
  logic [4:0]  exp_a, exp_b;

  logic [21:0]       prod_m;
  logic signed [6:0] exp_m;

  logic [10:0]       sig_n;
  logic              guard_n;
  logic              sticky_n;
  logic signed [6:0] exp_n;

  fp16_t rp_res;
  logic  rp_v, rp_z;

  fp16_t res_nxt;
  logic  n_nxt, v_nxt, z_nxt;
  logic  is_nan, is_inf, is_zero;

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // fixed sequence once started
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = UNPACK;
      UNPACK:  state_nxt = MULT;
      MULT:    state_nxt = NORM;
      NORM:    state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // operand capture on accepted start
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q <= '0;
      b_q <= '0;
    end else if (state == IDLE && start) begin
      a_q <= A;
      b_q <= B;
    end
  end

  // field split, classification, hidden bit
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sign_u <= 1'b0;
      cls_a  <= ZERO;
      cls_b  <= ZERO;
      sig_a  <= '0;
      sig_b  <= '0;
      exp_a  <= '0;
      exp_b  <= '0;
    end else if (state == UNPACK) begin
      sign_u <= a_q.sign ^ b_q.sign;
      cls_a  <= fp16_classify(a_q);
      cls_b  <= fp16_classify(b_q);
      sig_a  <= {1'b1, a_q.frac};
      sig_b  <= {1'b1, b_q.frac};
      exp_a  <= a_q.exp;
      exp_b  <= b_q.exp;
    end
  end

  // significand product and signed biased exponent
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prod_m <= '0;
      exp_m  <= '0;
    end else if (state == MULT) begin
      prod_m <= {11'd0, sig_a} * {11'd0, sig_b};
      exp_m  <= $signed({2'b00, exp_a})
              + $signed({2'b00, exp_b})
              - 7'(FP16_BIAS);
    end
  end

  // normalise to 11 bits plus guard/sticky
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sig_n    <= '0;
      guard_n  <= 1'b0;
      sticky_n <= 1'b0;
      exp_n    <= '0;
    end else if (state == NORM) begin
      if (prod_m[21]) begin
        sig_n    <= prod_m[21:11];
        guard_n  <= prod_m[10];
        sticky_n <= |prod_m[9:0];
        exp_n    <= exp_m + 7'sd1;
      end else begin
        sig_n    <= prod_m[20:10];
        guard_n  <= prod_m[9];
        sticky_n <= |prod_m[8:0];
        exp_n    <= exp_m;
      end
    end
  end

  fp16_round_pack u_round (
    .sign   (sign_u),
    .exp_in (exp_n),
    .sig    (sig_n),
    .guard  (guard_n),
    .sticky (sticky_n),
    .result (rp_res),
    .v      (rp_v),
    .z      (rp_z)
  );

  // special-case priority over the rounded result
  always_comb begin
    is_nan  = (cls_a == NAN) || (cls_b == NAN)
           || (cls_a == INF && cls_b == ZERO)
           || (cls_a == ZERO && cls_b == INF);
    is_inf  = (cls_a == INF) || (cls_b == INF);
    is_zero = (cls_a == ZERO) || (cls_b == ZERO);
    res_nxt = rp_res;
    v_nxt   = rp_v;
    z_nxt   = rp_z;
    if (is_nan) begin
      res_nxt = FP16_QNAN;
      v_nxt   = 1'b0;
      z_nxt   = 1'b0;
    end else if (is_inf) begin
      res_nxt = {sign_u, FP16_EXP_MAX, 10'h0};
      v_nxt   = 1'b0;
      z_nxt   = 1'b0;
    end else if (is_zero) begin
      res_nxt = {sign_u, 15'h0};
      v_nxt   = 1'b0;
      z_nxt   = 1'b1;
    end
    n_nxt = ~is_nan & res_nxt.sign;
  end

  // result registers, written once per operation
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      product <= 16'h0000;
      n       <= 1'b0;
      v       <= 1'b0;
      z       <= 1'b0;
      ready   <= 1'b0;
    end else begin
      ready <= (state == DONE);
      if (state == DONE) begin
        product <= res_nxt;
        n       <= n_nxt;
        v       <= v_nxt;
        z       <= z_nxt;
      end
    end
  end

endmodule
